// File: rtl/ram_pkg.sv
// ram_pkg: shared types and widths for the controller-to-RAM responder.
//   ram_state_t : responder transaction state
//   RAM_DATA_W  : data word width
//   RAM_ADDR_W  : byte address width on the A channel
//   LAT_W       : width of the read latency counter (latency 1..15)
package ram_pkg;

    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned RAM_ADDR_W = 32;
    localparam int unsigned LAT_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// ram_array: single-port synchronous word memory, one read or write per cycle.
//   clock   : rising-edge clock
//   i_en    : access enable
//   i_we    : 1 = write i_wdata to i_addr, 0 = read i_addr into o_rdata
//   i_addr  : word index
//   i_wdata : write word
//   o_rdata : registered read word, holds its value until the next read
// Storage and the read register are intentionally not reset.
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [RAM_DATA_W-1:0] i_wdata,
    output logic [RAM_DATA_W-1:0] o_rdata
);

    logic [RAM_DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [RAM_DATA_W-1:0] r_rdata;

    // Single port: write or registered read, never both in one cycle.
    always_ff @(posedge clock) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// ram_responder: RAM-side responder for the A (address), W (write data) and
// R (read data) channels, one transaction at a time, programmable read latency.
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   cntl2ram_a_*         : address beat in (valid/write/addr), a_ready out
//   cntl2ram_w_*         : write data beat in (valid/data), w_ready out
//   ram2cntl_r_*         : read data beat out (valid/data), r_ready in
//   err_misaligned       : sticky flag, an accepted address had addr[1:0] != 0
// Handshake outputs are decoded from the state register only.
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cntl2ram_a_valid,
    output logic                  cntl2ram_a_ready,
    input  logic                  cntl2ram_a_write,
    input  logic [RAM_ADDR_W-1:0] cntl2ram_a_addr,
    input  logic                  cntl2ram_w_valid,
    output logic                  cntl2ram_w_ready,
    input  logic [RAM_DATA_W-1:0] cntl2ram_w_data,
    output logic                  ram2cntl_r_valid,
    input  logic                  ram2cntl_r_ready,
    output logic [RAM_DATA_W-1:0] ram2cntl_r_data,
    output logic                  err_misaligned
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    ram_state_t            r_state;
    ram_state_t            w_next_state;
    logic [AW-1:0]         r_index;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [RAM_DATA_W-1:0] r_data;
    logic                  r_err;

    logic [AW-1:0]         w_a_index;
    logic                  w_a_ready;
    logic                  w_w_ready;
    logic                  w_r_valid;
    logic                  w_arr_en;
    logic                  w_arr_we;
    logic [AW-1:0]         w_arr_addr;
    logic [RAM_DATA_W-1:0] w_arr_rdata;
    logic                  w_unused_addr_bits;

    // Word index; upper address bits are ignored so addresses wrap modulo depth.
    assign w_a_index          = cntl2ram_a_addr[AW+1:2];
    assign w_unused_addr_bits = ^cntl2ram_a_addr[RAM_ADDR_W-1:AW+2];

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (cntl2ram_a_valid) begin
                    w_next_state = cntl2ram_a_write ? WR_DATA : RD_WAIT;
                end
            end
            WR_DATA: begin
                if (cntl2ram_w_valid) begin
                    w_next_state = IDLE;
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_next_state = RD_RESP;
                end
            end
            RD_RESP: begin
                if (ram2cntl_r_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output and array-control decode. Reads are issued straight off the
    // A beat so the array output is ready well before the latency expires.
    always_comb begin
        w_a_ready  = 1'b0;
        w_w_ready  = 1'b0;
        w_r_valid  = 1'b0;
        w_arr_en   = 1'b0;
        w_arr_we   = 1'b0;
        w_arr_addr = r_index;
        case (r_state)
            IDLE: begin
                w_a_ready  = 1'b1;
                w_arr_en   = cntl2ram_a_valid & ~cntl2ram_a_write;
                w_arr_addr = w_a_index;
            end
            WR_DATA: begin
                w_w_ready = 1'b1;
                w_arr_en  = cntl2ram_w_valid;
                w_arr_we  = 1'b1;
            end
            RD_RESP: begin
                w_r_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Transaction registers: index, latency counter, response word, error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_index   <= '0;
            r_lat_cnt <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == IDLE) && cntl2ram_a_valid) begin
                r_index   <= w_a_index;
                r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
                if (cntl2ram_a_addr[1:0] != 2'b00) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == RD_WAIT) begin
                if (r_lat_cnt == '0) begin
                    r_data <= w_arr_rdata;
                end else begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                end
            end
        end
    end

    ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .i_en    (w_arr_en),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_wdata (cntl2ram_w_data),
        .o_rdata (w_arr_rdata)
    );

    assign cntl2ram_a_ready = w_a_ready;
    assign cntl2ram_w_ready = w_w_ready;
    assign ram2cntl_r_valid = w_r_valid;
    assign ram2cntl_r_data  = r_data;
    assign err_misaligned   = r_err;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed plus randomized bench for ram_responder with a
// word-indexed memory model and sticky misalignment model.
module tb_ram_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RL    = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic        a_write;
    logic [31:0] a_addr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic        err_mis;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] mem_model [int];
    logic        exp_mis;

    always #5 clock = ~clock;

    ram_responder #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cntl2ram_a_valid (a_valid),
        .cntl2ram_a_ready (a_ready),
        .cntl2ram_a_write (a_write),
        .cntl2ram_a_addr  (a_addr),
        .cntl2ram_w_valid (w_valid),
        .cntl2ram_w_ready (w_ready),
        .cntl2ram_w_data  (w_data),
        .ram2cntl_r_valid (r_valid),
        .ram2cntl_r_ready (r_ready),
        .ram2cntl_r_data  (r_data),
        .err_misaligned   (err_mis)
    );

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % 32'(DEPTH));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int wait_cyc);
        check("wr_a_ready", 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        a_write = 1'b1;
        a_addr  = addr;
        tick();
        a_valid = 1'b0;
        a_write = 1'b0;
        if (addr[1:0] != 2'b00) exp_mis = 1'b1;
        check("wr_w_ready", 32'(w_ready), 32'd1);
        check("wr_a_busy", 32'(a_ready), 32'd0);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            check("wr_w_wait", 32'(w_ready), 32'd1);
        end
        w_valid = 1'b1;
        w_data  = data;
        tick();
        w_valid = 1'b0;
        mem_model[widx(addr)] = data;
        check("wr_idle_a_ready", 32'(a_ready), 32'd1);
        check("wr_idle_w_ready", 32'(w_ready), 32'd0);
        check("wr_err_mis", 32'(err_mis), 32'(exp_mis));
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        int          lat;
        logic [31:0] first;
        check("rd_a_ready", 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        a_write = 1'b0;
        a_addr  = addr;
        tick();
        a_valid = 1'b0;
        if (addr[1:0] != 2'b00) exp_mis = 1'b1;
        lat = 0;
        while (r_valid !== 1'b1 && lat < 40) begin
            check("rd_wait_a_busy", 32'(a_ready), 32'd0);
            tick();
            lat++;
        end
        check("rd_latency", 32'(lat), 32'(RL));
        check("rd_w_ready_low", 32'(w_ready), 32'd0);
        if (mem_model.exists(widx(addr))) begin
            check("rd_data", r_data, mem_model[widx(addr)]);
        end
        first = r_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("rd_stall_valid", 32'(r_valid), 32'd1);
            check("rd_stall_data", r_data, first);
            check("rd_stall_a_busy", 32'(a_ready), 32'd0);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("rd_done_valid", 32'(r_valid), 32'd0);
        check("rd_done_a_ready", 32'(a_ready), 32'd1);
        check("rd_err_mis", 32'(err_mis), 32'(exp_mis));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] hi;
        logic [31:0] base;
        logic [31:0] lo;
        hi   = 32'($urandom_range(0, 7));
        base = 32'($urandom_range(0, 31));
        lo   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
        return (hi << 12) | (base << 2) | lo;
    endfunction

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b0;
        a_write = 1'b0;
        a_addr  = '0;
        w_valid = 1'b0;
        w_data  = '0;
        r_ready = 1'b0;
        exp_mis = 1'b0;

        // Reset held three cycles.
        repeat (3) tick();
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_w_ready", 32'(w_ready), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_err_mis", 32'(err_mis), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic write then read.
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 0);
        do_read(32'h0000_0010, 0);
        check("rd_deadbeef", r_data, 32'hDEAD_BEEF);

        // Read held off by r_ready low for five cycles.
        do_read(32'h0000_0010, 5);

        // Address wrap modulo depth.
        do_write(32'h0000_1004, 32'h1111_1111, 2);
        do_read(32'h0000_0004, 0);
        check("rd_wrap", r_data, 32'h1111_1111);

        // W beat offered while idle is not accepted and changes nothing.
        w_valid = 1'b1;
        w_data  = 32'h0BAD_0BAD;
        tick();
        check("idle_w_ready", 32'(w_ready), 32'd0);
        check("idle_a_ready", 32'(a_ready), 32'd1);
        w_valid = 1'b0;
        do_read(32'h0000_0010, 0);

        // Misaligned write lands at word index 8; flag stays set.
        do_write(32'h0000_0022, 32'hCAFE_F00D, 1);
        check("mis_flag", 32'(err_mis), 32'd1);
        do_read(32'h0000_0020, 0);
        check("mis_data", r_data, 32'hCAFE_F00D);
        do_read(32'h0000_0010, 1);
        check("mis_sticky", 32'(err_mis), 32'd1);

        // Reset while waiting for write data: write dropped.
        a_valid = 1'b1;
        a_write = 1'b1;
        a_addr  = 32'h0000_0010;
        tick();
        a_valid = 1'b0;
        a_write = 1'b0;
        check("rstwr_w_ready", 32'(w_ready), 32'd1);
        w_valid = 1'b1;
        w_data  = 32'h0BAD_BAD0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rstwr_async_a_ready", 32'(a_ready), 32'd1);
        check("rstwr_async_w_ready", 32'(w_ready), 32'd0);
        tick();
        tick();
        w_valid = 1'b0;
        reset_n = 1'b1;
        exp_mis = 1'b0;
        tick();
        check("rstwr_idle", 32'(a_ready), 32'd1);
        check("rstwr_err_clr", 32'(err_mis), 32'd0);
        do_read(32'h0000_0010, 0);
        check("rstwr_old_data", r_data, 32'hDEAD_BEEF);

        // Randomized mix of writes and reads against the model.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] addr;
            addr = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, $urandom(), int'($urandom_range(0, 3)));
            end else begin
                do_read(addr, int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
